cam_stream_gen: RTL and testbench
=================================

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- AW, 15: pixel address width.
- DW, 3: pixel data width, RGB111 with [2]=R, [1]=G, [0]=B.
- H_PIX, 160: pixels per line.
- V_LINES, 120: active lines per frame.
- H_BLANK, 16: HREF-low cycles per line.
- VS_LINES, 3: VSYNC-high duration in lines.
- VB_LINES, 2: back-porch duration in lines.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- P_clk, in, 1: sole clock; rising-edge only.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: level; start or continue frame generation.
- pattern_en, in, 1: 1 selects the internal colour-bar source, 0 selects the RAM source.
- addr_r, out, AW: pixel read address to the frame buffer.
- data_r, in, DW: pixel read data, valid 1 cycle after addr_r.
- VSYNC, out, 1: frame sync, active high.
- HREF, out, 1: line valid, active high.
- D, out, 8: camera-format byte stream, RGB565, 2 bytes per pixel.
- frame_done, out, 1: single-cycle end-of-frame pulse.
- busy, out, 1: high whenever the FSM is not in IDLE.
REQ-003 SHALL register VSYNC, HREF, D, frame_done and busy.

Function
REQ-004 SHALL implement FSM states IDLE, VSYNC, VBACK, ACTIVE and HBLANK.
REQ-005 SHALL define LINE_CYC = 2*H_PIX + H_BLANK cycles.
REQ-006 In IDLE, enable=1 sampled at an edge SHALL cause VSYNC=1 from the next cycle.
REQ-007 VSYNC SHALL stay high for exactly VS_LINES*LINE_CYC cycles, with HREF=0.
REQ-008 VBACK SHALL last VB_LINES*LINE_CYC cycles, with VSYNC=0 and HREF=0.
REQ-009 Each active line SHALL consist of HREF=1 for 2*H_PIX cycles, then HREF=0 for H_BLANK cycles.
REQ-010 The FSM SHALL repeat the line sequence for V_LINES lines.
REQ-011 Pixel n SHALL occupy 2 consecutive HREF-high cycles, first byte then second byte.
REQ-012 With R5={5{R}}, G6={6{G}} and B5={5{B}}, the first byte SHALL be {R5, G6[5:3]}.
REQ-013 The second byte SHALL be {G6[2:0], B5}.
REQ-014 D SHALL be 8'h00 whenever HREF=0.
REQ-015 addr_r SHALL equal line*H_PIX + col, covering 0 to H_PIX*V_LINES-1, with no wrap within a frame.
REQ-016 addr_r for pixel n SHALL be stable at least 1 cycle before the first byte of pixel n, prefetched during the preceding byte or blank cycle.
REQ-017 addr_r SHALL return to 0 at the start of every frame.
REQ-018 When pattern_en=1, pixel data SHALL be {col[2],col[1],col[0]} of the bar index col*8/H_PIX, in place of data_r.
REQ-019 addr_r SHALL still advance when pattern_en=1.
REQ-020 pattern_en SHALL be sampled only at frame start and held for the whole frame.
REQ-021 frame_done SHALL pulse high for exactly the last HBLANK cycle of line V_LINES-1.
REQ-022 After the last HBLANK cycle, enable=1 SHALL start a new VSYNC on the next cycle, with no gap.
REQ-023 After the last HBLANK cycle, enable=0 SHALL return the FSM to IDLE.
REQ-024 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame SHALL complete.
REQ-025 Total frame length SHALL be (VS_LINES+VB_LINES+V_LINES)*LINE_CYC cycles.
REQ-026 Internal counters SHALL be sized by $clog2 of their maximum values, and no counter SHALL overflow for the default parameters.

Reset
REQ-027 reset=1 SHALL force IDLE asynchronously.
REQ-028 reset=1 SHALL force VSYNC=0, HREF=0, D=8'h00, addr_r=0, frame_done=0 and busy=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_done.
REQ-030 After reset release, the block SHALL await enable=1 in IDLE.

Verification (H_PIX=4, V_LINES=2, H_BLANK=2, VS_LINES=1, VB_LINES=1, so LINE_CYC=10)
REQ-031 Enable=1 from reset SHALL give VSYNC high for 10 cycles, 10 idle cycles, then HREF high for 8 cycles and low for 2 cycles, twice.
REQ-032 The sequence in REQ-031 SHALL give frame_done at cycle 40 and the next VSYNC at cycle 41.
REQ-033 RAM model returning data_r=3'b101 SHALL produce D=8'hF8 then 8'h1F for each pixel.
REQ-034 RAM model returning data_r=3'b010 SHALL produce D=8'h07 then 8'hE0 for each pixel.
REQ-035 Capturing addr_r alongside the byte stream SHALL show addresses 0,1,2,3 on line 0 and 4,5,6,7 on line 1, each stable before its first byte.
REQ-036 A checker SHALL confirm D=0 during every HREF=0 cycle.
REQ-037 enable dropped during line 0 SHALL still complete the frame with frame_done, then busy=0 and VSYNC stays 0.
REQ-038 reset pulsed during HREF high SHALL take all outputs to 0 at once and produce no frame_done.
REQ-039 After the reset in REQ-038, enable=1 SHALL restart the frame with addr_r=0.
REQ-040 pattern_en=1 at frame start SHALL give pixels 0,1,2,3 values 000, 010, 100, 110, i.e. bytes 00/00, 07/E0, F8/00, FF/E0.
REQ-041 Toggling pattern_en mid-frame SHALL have no effect until the next frame.

Source files
------------

// File: rtl/cam_stream_gen.sv
// cam_stream_gen: synthetic camera timing generator.
// Produces a VSYNC / back-porch / active-line frame with RGB565 bytes on D,
// two bytes per pixel. Pixels come from a frame buffer read port
// (addr_r -> data_r) or from an internal 8-bar colour pattern.
//
// Read port contract: this block presents addr_r and expects data_r for that
// address exactly one cycle later. There is no valid/ready pair; the read
// latency is fixed. addr_r for pixel n is presented two cycles before the
// first byte of pixel n and held for at least those two cycles.
module cam_stream_gen #(
    parameter int AW       = 15,
    parameter int DW       = 3,
    parameter int H_PIX    = 160,
    parameter int V_LINES  = 120,
    parameter int H_BLANK  = 16,
    parameter int VS_LINES = 3,
    parameter int VB_LINES = 2
) (
    input  logic          P_clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          pattern_en,
    output logic [AW-1:0] addr_r,
    input  logic [DW-1:0] data_r,
    output logic          VSYNC,
    output logic          HREF,
    output logic [7:0]    D,
    output logic          frame_done,
    output logic          busy
);

    // Line and phase lengths in clock cycles
    localparam int LINE_CYC = 2 * H_PIX + H_BLANK;
    localparam int VS_LEN   = VS_LINES * LINE_CYC;
    localparam int VB_LEN   = VB_LINES * LINE_CYC;
    localparam int ACT_LEN  = 2 * H_PIX;

    // One phase counter is shared by all states, so it is sized for the longest phase
    localparam int PH_MAX_A = (VS_LEN > VB_LEN) ? VS_LEN : VB_LEN;
    localparam int PH_MAX_B = (ACT_LEN > H_BLANK) ? ACT_LEN : H_BLANK;
    localparam int PH_MAX   = (PH_MAX_A > PH_MAX_B) ? PH_MAX_A : PH_MAX_B;
    localparam int CNT_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int LINE_W   = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int COL_W    = (H_PIX > 1) ? $clog2(H_PIX) : 1;

    localparam logic [CNT_W-1:0]   VS_LAST   = CNT_W'(VS_LEN - 1);
    localparam logic [CNT_W-1:0]   VB_LAST   = CNT_W'(VB_LEN - 1);
    localparam logic [CNT_W-1:0]   ACT_LAST  = CNT_W'(ACT_LEN - 1);
    localparam logic [CNT_W-1:0]   HB_LAST   = CNT_W'(H_BLANK - 1);
    localparam logic [LINE_W-1:0]  LINE_LAST = LINE_W'(V_LINES - 1);
    localparam logic [AW-1:0]      ADDR_LAST = AW'(H_PIX * V_LINES - 1);
    localparam logic [COL_W+2:0]   H_PIX_W   = (COL_W + 3)'(H_PIX);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                pat_q, pat_d;
    logic [2:0]          pix_q, pix_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic [7:0]          d_q, d_d;
    logic                fd_q, fd_d;
    logic                busy_q, busy_d;

    // Datapath helpers
    logic                first_byte;
    logic [COL_W-1:0]    col;
    logic [2:0]          bar;
    logic [2:0]          src_pix;

    // RGB111 -> RGB565 byte split: R5 = {5{R}}, G6 = {6{G}}, B5 = {5{B}}
    function automatic logic [7:0] rgb_hi(input logic [2:0] p);
        return {{5{p[2]}}, {3{p[1]}}};
    endfunction

    function automatic logic [7:0] rgb_lo(input logic [2:0] p);
        return {{3{p[1]}}, {5{p[0]}}};
    endfunction

    // Frame sequencing: phase, line counter and frame-start pattern latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        pat_d   = pat_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_VSYNC;
                    cnt_d   = '0;
                    line_d  = '0;
                    pat_d   = pattern_en;
                end
            end
            ST_VSYNC: begin
                if (cnt_q == VS_LAST) begin
                    state_d = ST_VBACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_VBACK: begin
                if (cnt_q == VB_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    line_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == ACT_LAST) begin
                    state_d = ST_HBLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (line_q == LINE_LAST) begin
                        // End of frame: chain straight into the next VSYNC or park.
                        line_d = '0;
                        if (enable) begin
                            state_d = ST_VSYNC;
                            pat_d   = pattern_en;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_ACTIVE;
                        line_d  = line_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                line_d  = '0;
            end
        endcase
    end

    // Pixel source selection and byte generation for the upcoming cycle
    always_comb begin
        first_byte = (state_d == ST_ACTIVE) && !cnt_d[0];
        col        = COL_W'(cnt_d >> 1);
        bar        = 3'({col, 3'b000} / H_PIX_W);
        src_pix    = pat_q ? bar : data_r[2:0];
        pix_d      = first_byte ? src_pix : pix_q;

        d_d = 8'h00;
        if (state_d == ST_ACTIVE) begin
            d_d = first_byte ? rgb_hi(src_pix) : rgb_lo(pix_q);
        end

        // Address leads the byte stream by two cycles; it steps when the
        // first byte of the pixel it currently points at is captured.
        addr_d = addr_q;
        if ((state_d == ST_VSYNC) && (state_q != ST_VSYNC)) begin
            addr_d = '0;
        end else if (first_byte && (addr_q != ADDR_LAST)) begin
            addr_d = addr_q + 1'b1;
        end

        vsync_d = (state_d == ST_VSYNC);
        href_d  = (state_d == ST_ACTIVE);
        busy_d  = (state_d != ST_IDLE);
        fd_d    = (state_d == ST_HBLANK) && (cnt_d == HB_LAST) && (line_d == LINE_LAST);
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge P_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            pat_q   <= 1'b0;
            pix_q   <= '0;
            addr_q  <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= 8'h00;
            fd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            pat_q   <= pat_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            d_q     <= d_d;
            fd_q    <= fd_d;
            busy_q  <= busy_d;
        end
    end

    assign addr_r     = addr_q;
    assign VSYNC      = vsync_q;
    assign HREF       = href_q;
    assign D          = d_q;
    assign frame_done = fd_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Bench for cam_stream_gen with a small frame (4x2 pixels, LINE_CYC = 10).
module tb_cam_stream_gen;

    localparam int AW       = 15;
    localparam int DW       = 3;
    localparam int H_PIX    = 4;
    localparam int V_LINES  = 2;
    localparam int H_BLANK  = 2;
    localparam int VS_LINES = 1;
    localparam int VB_LINES = 1;
    localparam int LINE_CYC = 2 * H_PIX + H_BLANK;
    localparam int FRAME    = (VS_LINES + VB_LINES + V_LINES) * LINE_CYC;
    localparam int NPIX     = H_PIX * V_LINES;

    // ---------------- clock / reset / DUT ----------------
    logic          P_clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          pattern_en;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] data_r;
    logic          VSYNC;
    logic          HREF;
    logic [7:0]    D;
    logic          frame_done;
    logic          busy;

    always #5 P_clk = ~P_clk;

    cam_stream_gen #(
        .AW(AW), .DW(DW), .H_PIX(H_PIX), .V_LINES(V_LINES),
        .H_BLANK(H_BLANK), .VS_LINES(VS_LINES), .VB_LINES(VB_LINES)
    ) dut (
        .P_clk(P_clk), .reset(reset), .enable(enable), .pattern_en(pattern_en),
        .addr_r(addr_r), .data_r(data_r), .VSYNC(VSYNC), .HREF(HREF), .D(D),
        .frame_done(frame_done), .busy(busy)
    );

    // Frame buffer model: one-cycle read latency
    logic [2:0] mem [0:NPIX-1];
    always @(posedge P_clk) data_r <= mem[addr_r[2:0]];

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  cap_bytes [0:2*NPIX-1];
    int          cap_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // D must be zero whenever HREF is low
    always @(negedge P_clk) begin
        if (HREF !== 1'b1) check("d_zero_when_href_low", {24'h0, D}, 32'h0);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] byte_of(input logic [2:0] p, input bit second);
        logic [7:0] b;
        if (!second) b = (p[2] ? 8'hF8 : 8'h00) | (p[1] ? 8'h07 : 8'h00);
        else         b = (p[1] ? 8'hE0 : 8'h00) | (p[0] ? 8'h1F : 8'h00);
        return b;
    endfunction

    // Expected {VSYNC, HREF, frame_done, busy, D} in frame cycle c (1..FRAME)
    function automatic logic [11:0] model_cycle(input int c, input logic pat);
        int ph;
        int ln;
        int pos;
        int al;
        int col;
        logic vs;
        logic hr;
        logic fd;
        logic [2:0] p;
        logic [7:0] byt;
        ph  = c - 1;
        ln  = ph / LINE_CYC;
        pos = ph % LINE_CYC;
        al  = ln - VS_LINES - VB_LINES;
        vs  = (ln < VS_LINES);
        hr  = (al >= 0) && (pos < 2 * H_PIX);
        fd  = (c == FRAME);
        byt = 8'h00;
        if (hr) begin
            col = pos / 2;
            p   = pat ? 3'(col * 8 / H_PIX) : mem[al * H_PIX + col];
            byt = byte_of(p, (pos % 2) == 1);
        end
        return {vs, hr, fd, 1'b1, byt};
    endfunction

    // Pixel index whose first byte lands in frame cycle c, or -1
    function automatic int first_pixel_at(input int c);
        int ph;
        int pos;
        int al;
        if (c < 1 || c > FRAME) return -1;
        ph  = c - 1;
        pos = ph % LINE_CYC;
        al  = ph / LINE_CYC - VS_LINES - VB_LINES;
        if (al >= 0 && pos < 2 * H_PIX && (pos % 2) == 0) return al * H_PIX + pos / 2;
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge with the DUT idle or in its last frame cycle.
    task automatic run_frame(input logic pat, input int drop_at, input int toggle_at, input string tag);
        logic [11:0] exp;
        int k;
        pattern_en = pat;
        enable     = 1'b1;
        cap_n      = 0;
        for (int c = 1; c <= FRAME; c++) exp_q.push_back(model_cycle(c, pat));
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge P_clk);
            exp = exp_q.pop_front();
            check($sformatf("%s c%0d vs/href/fd/busy/D", tag, c),
                  {20'h0, VSYNC, HREF, frame_done, busy, D}, {20'h0, exp});
            if (c == 1) check($sformatf("%s addr_at_frame_start", tag), 32'(addr_r), 32'h0);
            k = first_pixel_at(c + 1);
            if (k >= 0) check($sformatf("%s addr_before_pix%0d", tag, k), 32'(addr_r), 32'(k));
            if (HREF === 1'b1 && cap_n < 2 * NPIX) begin
                cap_bytes[cap_n] = D;
                cap_n++;
            end
            if (c == drop_at) enable = 1'b0;
            if (c == toggle_at) pattern_en = ~pattern_en;
        end
    endtask

    task automatic check_idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge P_clk);
            check($sformatf("%s idle%0d vsync/href/fd/busy", tag, i),
                  {28'h0, VSYNC, HREF, frame_done, busy}, 32'h0);
        end
    endtask

    task automatic fill_mem(input logic [2:0] v);
        for (int i = 0; i < NPIX; i++) mem[i] = v;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < NPIX; i++) mem[i] = 3'($urandom_range(0, 7));
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        pat;
        logic [2:0]  fill;
        logic [63:0] line0;   // eight expected bytes of line 0, first byte in MSBs
    } vec_t;

    vec_t tbl [0:3];

    // ---------------- main sequence ----------------
    initial begin
        tbl[0] = '{pat: 1'b0, fill: 3'b101, line0: 64'hF81F_F81F_F81F_F81F};
        tbl[1] = '{pat: 1'b0, fill: 3'b010, line0: 64'h07E0_07E0_07E0_07E0};
        tbl[2] = '{pat: 1'b1, fill: 3'b101, line0: 64'h0000_07E0_F800_FFE0};
        tbl[3] = '{pat: 1'b1, fill: 3'b011, line0: 64'h0000_07E0_F800_FFE0};

        reset      = 1'b1;
        enable     = 1'b0;
        pattern_en = 1'b0;
        fill_mem(3'b000);

        repeat (3) @(negedge P_clk);
        check("reset_outputs", {12'h0, VSYNC, HREF, frame_done, busy, D, addr_r[7:0]}, 32'h0);
        check("reset_addr", 32'(addr_r), 32'h0);
        reset = 1'b0;
        check_idle(3, "after_reset");

        // Table frames run back to back; the first starts from IDLE.
        for (int r = 0; r < 4; r++) begin
            fill_mem(tbl[r].fill);
            run_frame(tbl[r].pat, 0, 0, $sformatf("tbl%0d", r));
            for (int i = 0; i < 2 * H_PIX; i++)
                check($sformatf("tbl%0d line0_byte%0d", r, i),
                      {24'h0, cap_bytes[i]}, {24'h0, tbl[r].line0[63 - 8 * i -: 8]});
        end
        enable = 1'b0;
        check_idle(4, "after_table");

        // enable dropped during line 0: frame still completes, then idle
        rand_mem();
        run_frame(1'b0, 23, 0, "drop_en");
        check_idle(4, "after_drop");

        // pattern_en toggled mid-frame has no effect on this frame
        rand_mem();
        run_frame(1'b0, 0, 24, "toggle_pat");
        run_frame(1'b1, 0, 12, "toggle_pat2");
        enable = 1'b0;
        check_idle(2, "after_toggle");

        // Reset during HREF high aborts immediately with no frame_done
        rand_mem();
        pattern_en = 1'b0;
        enable     = 1'b1;
        repeat (24) @(negedge P_clk);
        check("mid_frame_href_high", {31'h0, HREF}, 32'h1);
        #2 reset = 1'b1;
        enable = 1'b0;
        #1;
        check("async_reset_outputs", {12'h0, VSYNC, HREF, frame_done, busy, D, addr_r[7:0]}, 32'h0);
        check("async_reset_addr", 32'(addr_r), 32'h0);
        @(negedge P_clk);
        reset = 1'b0;
        check_idle(6, "after_abort");
        run_frame(1'b0, 0, 0, "restart");
        enable = 1'b0;
        check_idle(2, "after_restart");

        // Randomised back-to-back frames
        for (int r = 0; r < 6; r++) begin
            rand_mem();
            run_frame(1'($urandom_range(0, 1)), 0,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, FRAME - 1)) : 0,
                      $sformatf("rnd%0d", r));
        end
        enable = 1'b0;
        check_idle(3, "after_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
